// File: rtl/frame_pingpong_buf.sv
// Two-bank frame buffer. A writer fills one bank by address, then commits it
// with wr_frame_done. Committed banks are streamed out in address order over a
// valid/ready interface while the writer fills the other bank.
module frame_pingpong_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 5100,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_frame_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              frame_busy,
    output logic              wr_bank,
    output logic              ovf,
    output logic              addr_err,
    input  logic              clr_flags,
    output logic [15:0]       frame_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRIME  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;

    logic [1:0]        bank_full;
    logic [1:0]        bank_full_nxt;
    logic              wr_bank_nxt;
    logic              commit_drop;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              rd_bank;
    logic              rd_bank_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_en;

    logic              xfer;
    logic              release_rd;
    logic              wr_ok;
    logic              wr_bad;

    // The word on m_data always sits in the read register of the bank being
    // streamed; rd_addr is the address of that word.
    assign m_valid    = (state == ST_STREAM);
    assign m_last     = m_valid && (rd_addr == LAST_ADDR);
    assign m_data     = rd_bank ? rd_data1 : rd_data0;
    assign xfer       = m_valid && m_ready;
    assign release_rd = xfer && m_last;
    assign wr_ok      = wr_en && ({1'b0, wr_addr} < DEPTH_X);
    assign wr_bad     = wr_en && !wr_ok;

    // Bank ownership: release of the streamed bank is applied before a commit
    // is judged, so a commit landing on the final transfer still succeeds.
    always_comb begin
        bank_full_nxt = bank_full;
        wr_bank_nxt   = wr_bank;
        commit_drop   = 1'b0;
        if (release_rd) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (wr_frame_done) begin
            if (!bank_full_nxt[~wr_bank]) begin
                bank_full_nxt[wr_bank] = 1'b1;
                wr_bank_nxt            = ~wr_bank;
            end else begin
                commit_drop = 1'b1;
            end
        end
    end

    // Reader next state: PRIME loads word 0, each non-final transfer loads the
    // following word so a held m_ready gives one word per cycle.
    always_comb begin
        state_nxt   = state;
        rd_bank_nxt = rd_bank;
        rd_addr_nxt = rd_addr;
        rd_en       = 1'b0;
        rd_ptr      = rd_addr + ADDR_ONE;
        case (state)
            ST_IDLE: begin
                if (|bank_full) begin
                    state_nxt   = ST_PRIME;
                    rd_bank_nxt = ~bank_full[0];
                    rd_addr_nxt = '0;
                end
            end
            ST_PRIME: begin
                rd_en       = 1'b1;
                rd_ptr      = '0;
                rd_addr_nxt = '0;
                state_nxt   = ST_STREAM;
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (m_last) begin
                        rd_addr_nxt = '0;
                        if (bank_full_nxt[~rd_bank]) begin
                            state_nxt   = ST_PRIME;
                            rd_bank_nxt = ~rd_bank;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        rd_en       = 1'b1;
                        rd_addr_nxt = rd_ptr;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control registers: bank states, write bank, reader FSM, busy and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full  <= 2'b00;
            wr_bank    <= 1'b0;
            state      <= ST_IDLE;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            frame_busy <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            bank_full  <= bank_full_nxt;
            wr_bank    <= wr_bank_nxt;
            state      <= state_nxt;
            rd_bank    <= rd_bank_nxt;
            rd_addr    <= rd_addr_nxt;
            frame_busy <= (|bank_full_nxt) || (state_nxt != ST_IDLE);
            if (release_rd) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf      <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            ovf      <= commit_drop || (ovf && !clr_flags);
            addr_err <= wr_bad || (addr_err && !clr_flags);
        end
    end

    // Bank 0 write port.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok && !wr_bank) begin
            mem0[wr_addr] <= wr_data;
        end
    end

    // Bank 1 write port.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok && wr_bank) begin
            mem1[wr_addr] <= wr_data;
        end
    end

    // Bank 0 synchronous read register, only advanced when a word is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data0 <= '0;
        end else if (rd_en && !rd_bank) begin
            rd_data0 <= mem0[rd_ptr];
        end
    end

    // Bank 1 synchronous read register, only advanced when a word is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data1 <= '0;
        end else if (rd_en && rd_bank) begin
            rd_data1 <= mem1[rd_ptr];
        end
    end

endmodule

// File: tb/tb_frame_pingpong_buf.sv
// Bench for frame_pingpong_buf: randomized frames against a queue-based model
// of bank ownership and frame order (DEPTH=8), plus a DEPTH=6 instance for
// out-of-range write addresses.
module tb_frame_pingpong_buf;

    localparam int D  = 8;
    localparam int D6 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_frame_done = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;
    logic        frame_busy;
    logic        wr_bank;
    logic        ovf;
    logic        addr_err;
    logic        clr_flags = 1'b0;
    logic [15:0] frame_cnt;

    logic        wr_en6 = 1'b0;
    logic [2:0]  wr_addr6 = '0;
    logic [7:0]  wr_data6 = '0;
    logic        done6 = 1'b0;
    logic        m_valid6;
    logic        m_ready6 = 1'b0;
    logic [7:0]  m_data6;
    logic        m_last6;
    logic        frame_busy6;
    logic        wr_bank6;
    logic        ovf6;
    logic        addr_err6;
    logic        clr6 = 1'b0;
    logic [15:0] frame_cnt6;

    frame_pingpong_buf #(.DATA_W(8), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_frame_done(wr_frame_done), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .frame_busy(frame_busy), .wr_bank(wr_bank), .ovf(ovf),
        .addr_err(addr_err), .clr_flags(clr_flags), .frame_cnt(frame_cnt)
    );

    frame_pingpong_buf #(.DATA_W(8), .DEPTH(D6)) dut6 (
        .clk(clk), .reset(reset), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
        .wr_frame_done(done6), .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6),
        .m_last(m_last6), .frame_busy(frame_busy6), .wr_bank(wr_bank6), .ovf(ovf6),
        .addr_err(addr_err6), .clr_flags(clr6), .frame_cnt(frame_cnt6)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bank contents, owner of writes, FULL flags and the
    // sequence of words still owed to the consumer.
    logic [7:0] mm [2][D];
    int         mwb;
    bit         mfull [2];
    logic [7:0] q_data [$];
    int         q_bank [$];
    int         widx;
    int         mcnt;
    bit         movf;

    task automatic model_reset();
        mwb = 0; mfull[0] = 0; mfull[1] = 0;
        q_data.delete(); q_bank.delete();
        widx = 0; mcnt = 0; movf = 0;
    endtask

    // One clock: updates the model from the inputs already driven, then
    // advances the DUT; reports whether a transfer happened and what was owed.
    task automatic step(input bit done, output bit xf, output bit sp,
                        output logic [7:0] gd, output logic gl,
                        output logic [7:0] ed, output logic el);
        bit drop;
        int b;
        xf = (m_valid === 1'b1) && (m_ready === 1'b1);
        gd = m_data; gl = m_last;
        ed = 8'h00; el = 1'b0; sp = 0; drop = 0;
        wr_frame_done = done;
        if (xf) begin
            if (q_data.size() == 0) begin
                sp = 1;
            end else begin
                ed = q_data.pop_front();
                el = (widx == D - 1);
                widx++;
                if (widx == D) begin
                    widx = 0;
                    b = q_bank.pop_front();
                    mfull[b] = 0;
                    mcnt = (mcnt + 1) & 16'hFFFF;
                end
            end
        end
        if (wr_en) mm[mwb][wr_addr] = wr_data;
        if (done) begin
            if (!mfull[1 - mwb]) begin
                for (int i = 0; i < D; i++) q_data.push_back(mm[mwb][i]);
                q_bank.push_back(mwb);
                mfull[mwb] = 1;
                mwb = 1 - mwb;
            end else begin
                drop = 1;
            end
        end
        movf = drop || (movf && !clr_flags);
        @(posedge clk); #1;
        wr_frame_done = 1'b0;
        wr_en = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic fill_random();
        bit xf, sp; logic [7:0] gd, ed; logic gl, el;
        for (int i = 0; i < D; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'($urandom);
            step(0, xf, sp, gd, gl, ed, el);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", m_last); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%h want=00", m_data); end
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", frame_busy); end
        total++; if (wr_bank !== 1'b0) begin bad++; $display("FAIL reset_wr_bank got=%b want=0", wr_bank); end
        total++; if (ovf !== 1'b0 || addr_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", ovf, addr_err); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit xf, sp; logic [7:0] gd, ed; logic gl, el;
        m_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(i);
            step(0, xf, sp, gd, gl, ed, el);
        end
        step(1, xf, sp, gd, gl, ed, el);
        total++; if (frame_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_commit got=%b want=1", frame_busy); end
        total++; if (wr_bank !== 1'(mwb)) begin bad++; $display("FAIL basic_wr_bank got=%b want=%0d", wr_bank, mwb); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early1 got=%b want=0", m_valid); end
        step(0, xf, sp, gd, gl, ed, el);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_early2 got=%b want=0", m_valid); end
        step(0, xf, sp, gd, gl, ed, el);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency got=%b want=1", m_valid); end
        for (int k = 0; k < D; k++) begin
            step(0, xf, sp, gd, gl, ed, el);
            total++; if (!xf) begin bad++; $display("FAIL basic_bubble word=%0d got=0 want=1", k); end
            if (xf) begin
                total++; if (sp || gd !== ed) begin bad++; $display("FAIL basic_data word=%0d got=%h want=%h", k, gd, ed); end
                total++; if (gl !== el) begin bad++; $display("FAIL basic_last word=%0d got=%b want=%b", k, gl, el); end
            end
        end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b want=0", m_valid); end
        total++; if (frame_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", frame_busy); end
        total++; if (frame_cnt !== 16'(mcnt)) begin bad++; $display("FAIL basic_frame_cnt got=%0d want=%0d", frame_cnt, mcnt); end
    endtask

    task automatic test_stall();
        bit xf, sp; logic [7:0] gd, ed; logic gl, el;
        logic pv, pr, pl; logic [7:0] pd;
        int n;
        m_ready = 1'b0;
        fill_random();
        step(1, xf, sp, gd, gl, ed, el);
        pv = 0; pr = 0; pl = 0; pd = 0; n = 0;
        for (int c = 0; c < 200 && n < D; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
                    bad++; $display("FAIL stall_hold got=%b/%h/%b want=1/%h/%b", m_valid, m_data, m_last, pd, pl);
                end
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            step(0, xf, sp, gd, gl, ed, el);
            if (xf) begin
                n++;
                total++; if (sp || gd !== ed || gl !== el) begin bad++; $display("FAIL stall_data n=%0d got=%h/%b want=%h/%b", n, gd, gl, ed, el); end
            end
        end
        total++; if (n != D) begin bad++; $display("FAIL stall_count got=%0d want=%0d", n, D); end
        m_ready = 1'b1;
        step(0, xf, sp, gd, gl, ed, el);
        total++; if (xf || m_valid !== 1'b0) begin bad++; $display("FAIL stall_extra got=%b want=0", m_valid); end
        total++; if (frame_cnt !== 16'(mcnt)) begin bad++; $display("FAIL stall_frame_cnt got=%0d want=%0d", frame_cnt, mcnt); end
    endtask

    task automatic test_overflow();
        bit xf, sp; logic [7:0] gd, ed; logic gl, el;
        int n;
        m_ready = 1'b0;
        fill_random();
        step(1, xf, sp, gd, gl, ed, el);
        fill_random();
        step(1, xf, sp, gd, gl, ed, el);
        total++; if (ovf !== 1'(movf) || movf != 1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf); end
        total++; if (wr_bank !== 1'(mwb)) begin bad++; $display("FAIL ovf_wr_bank got=%b want=%0d", wr_bank, mwb); end
        total++; if (frame_busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got=%b want=1", frame_busy); end
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && q_data.size() > 0; c++) begin
            step(0, xf, sp, gd, gl, ed, el);
            if (xf) begin
                n++;
                total++; if (sp || gd !== ed || gl !== el) begin bad++; $display("FAIL ovf_stream n=%0d got=%h/%b want=%h/%b", n, gd, gl, ed, el); end
            end
        end
        total++; if (n != D) begin bad++; $display("FAIL ovf_stream_count got=%0d want=%0d", n, D); end
        clr_flags = 1'b1;
        step(0, xf, sp, gd, gl, ed, el);
        total++; if (ovf !== 1'(movf) || movf != 0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf); end
    endtask

    task automatic test_back_to_back();
        bit xf, sp; logic [7:0] gd, ed; logic gl, el;
        logic [7:0] bdat [D];
        int wi, n;
        bit committed, done;
        m_ready = 1'b1;
        fill_random();
        step(1, xf, sp, gd, gl, ed, el);
        for (int i = 0; i < D; i++) bdat[i] = 8'($urandom);
        wi = 0; n = 0; committed = 0;
        for (int c = 0; c < 80 && !(committed && q_data.size() == 0); c++) begin
            done = 0;
            if (wi < D) begin
                wr_en = 1'b1; wr_addr = 3'(wi); wr_data = bdat[wi]; wi++;
            end else if (!committed && m_valid === 1'b1 && widx == D - 1) begin
                done = 1; committed = 1;
            end
            step(done, xf, sp, gd, gl, ed, el);
            if (xf) begin
                n++;
                total++; if (sp || gd !== ed || gl !== el) begin bad++; $display("FAIL b2b_stream n=%0d got=%h/%b want=%h/%b", n, gd, gl, ed, el); end
            end
            if (done) begin
                total++; if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b want=0", ovf); end
                total++; if (wr_bank !== 1'(mwb)) begin bad++; $display("FAIL b2b_wr_bank got=%b want=%0d", wr_bank, mwb); end
                total++; if (frame_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", frame_busy); end
            end
        end
        total++; if (!committed || n != 2 * D) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", n, 2 * D); end
        total++; if (frame_cnt !== 16'(mcnt)) begin bad++; $display("FAIL b2b_frame_cnt got=%0d want=%0d", frame_cnt, mcnt); end
    endtask

    task automatic test_reset_mid();
        bit xf, sp; logic [7:0] gd, ed; logic gl, el;
        int n;
        m_ready = 1'b1;
        fill_random();
        step(1, xf, sp, gd, gl, ed, el);
        for (int c = 0; c < 20 && !(widx == 3); c++) begin
            step(0, xf, sp, gd, gl, ed, el);
            if (xf) begin
                total++; if (sp || gd !== ed) begin bad++; $display("FAIL rstmid_pre got=%h want=%h", gd, ed); end
            end
        end
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'($urandom); wr_frame_done = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; wr_en = 1'b0; wr_frame_done = 1'b0;
        model_reset();
        total++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b%b want=00", m_valid, m_last); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", m_data); end
        total++; if (frame_busy !== 1'b0 || wr_bank !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=%b%b want=00", frame_busy, wr_bank); end
        total++; if (ovf !== 1'b0 || addr_err !== 1'b0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_stat got=%b%b/%0d want=00/0", ovf, addr_err, frame_cnt); end
        for (int c = 0; c < 4; c++) begin
            step(0, xf, sp, gd, gl, ed, el);
            total++; if (m_valid !== 1'b0 || frame_busy !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b%b want=00", m_valid, frame_busy); end
        end
        step(1, xf, sp, gd, gl, ed, el);
        n = 0;
        for (int c = 0; c < 30 && q_data.size() > 0; c++) begin
            step(0, xf, sp, gd, gl, ed, el);
            if (xf) begin
                n++;
                total++; if (sp || gd !== ed || gl !== el) begin bad++; $display("FAIL rstmid_stream n=%0d got=%h/%b want=%h/%b", n, gd, gl, ed, el); end
            end
        end
        total++; if (n != D || frame_cnt !== 16'(mcnt)) begin bad++; $display("FAIL rstmid_count got=%0d/%0d want=%0d/%0d", n, frame_cnt, D, mcnt); end
    endtask

    task automatic test_addr_err();
        logic [7:0] d6 [D6];
        bit xf; logic [7:0] gd; logic gl;
        int n;
        total++; if (addr_err6 !== 1'b0) begin bad++; $display("FAIL aerr_initial got=%b want=0", addr_err6); end
        for (int i = 0; i < D6; i++) begin
            d6[i] = 8'($urandom);
            wr_en6 = 1'b1; wr_addr6 = 3'(i); wr_data6 = d6[i];
            @(posedge clk); #1;
        end
        total++; if (addr_err6 !== 1'b0) begin bad++; $display("FAIL aerr_false got=%b want=0", addr_err6); end
        wr_addr6 = 3'd6; wr_data6 = ~d6[0];
        @(posedge clk); #1;
        total++; if (addr_err6 !== 1'b1) begin bad++; $display("FAIL aerr_set got=%b want=1", addr_err6); end
        wr_addr6 = 3'd7; wr_data6 = ~d6[1]; clr6 = 1'b1;
        @(posedge clk); #1;
        total++; if (addr_err6 !== 1'b1) begin bad++; $display("FAIL aerr_clr_collide got=%b want=1", addr_err6); end
        wr_en6 = 1'b0;
        @(posedge clk); #1;
        clr6 = 1'b0;
        total++; if (addr_err6 !== 1'b0) begin bad++; $display("FAIL aerr_clear got=%b want=0", addr_err6); end
        done6 = 1'b1; m_ready6 = 1'b1;
        @(posedge clk); #1;
        done6 = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < D6; c++) begin
            xf = (m_valid6 === 1'b1); gd = m_data6; gl = m_last6;
            @(posedge clk); #1;
            if (xf) begin
                total++; if (gd !== d6[n] || gl !== (n == D6 - 1)) begin bad++; $display("FAIL aerr_mem n=%0d got=%h/%b want=%h/%b", n, gd, gl, d6[n], (n == D6 - 1)); end
                n++;
            end
        end
        total++; if (n != D6 || frame_cnt6 !== 16'd1 || m_valid6 !== 1'b0) begin bad++; $display("FAIL aerr_frame got=%0d/%0d want=%0d/1", n, frame_cnt6, D6); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_addr_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
